// File: rtl/alu_sched_if.sv
// Requester, ALU and response signal bundle for the alu_sched ALU scheduler.
interface alu_sched_if #(
  parameter int DATA_W = 16,
  parameter int INST_W = 4,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // requester 0
  logic              i_req0_valid;
  logic              o_req0_ready;
  logic [INST_W-1:0] i_req0_inst;
  logic [DATA_W-1:0] i_req0_a;
  logic [DATA_W-1:0] i_req0_b;
  // requester 1
  logic              i_req1_valid;
  logic              o_req1_ready;
  logic [INST_W-1:0] i_req1_inst;
  logic [DATA_W-1:0] i_req1_a;
  logic [DATA_W-1:0] i_req1_b;
  // ALU side
  logic [INST_W-1:0] o_alu_inst;
  logic [DATA_W-1:0] o_alu_a;
  logic [DATA_W-1:0] o_alu_b;
  logic              i_alu_busy;
  logic              i_alu_valid;
  logic [DATA_W-1:0] i_alu_data;
  // response side
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic              o_rsp_id;
  logic [DATA_W-1:0] o_rsp_data;
  logic [CNT_W-1:0]  o_fifo_cnt;

  // scheduler side
  modport slave (
    input  i_req0_valid, i_req0_inst, i_req0_a, i_req0_b,
    input  i_req1_valid, i_req1_inst, i_req1_a, i_req1_b,
    output o_req0_ready, o_req1_ready,
    output o_alu_inst, o_alu_a, o_alu_b,
    input  i_alu_busy, i_alu_valid, i_alu_data,
    output o_rsp_valid, o_rsp_id, o_rsp_data,
    input  i_rsp_ready,
    output o_fifo_cnt
  );

  // environment side (requesters, ALU, response consumer)
  modport master (
    output i_req0_valid, i_req0_inst, i_req0_a, i_req0_b,
    output i_req1_valid, i_req1_inst, i_req1_a, i_req1_b,
    input  o_req0_ready, o_req1_ready,
    input  o_alu_inst, o_alu_a, o_alu_b,
    output i_alu_busy, i_alu_valid, i_alu_data,
    input  o_rsp_valid, o_rsp_id, o_rsp_data,
    output i_rsp_ready,
    input  o_fifo_cnt
  );
endinterface

// File: rtl/alu_sched.sv
// Shares one fixed-point ALU between two requesters: round-robin arbiter,
// command FIFO, issue FSM following the ALU busy/valid handshake, and a
// single-entry tagged response register.
module alu_sched #(
  parameter int DATA_W = 16,
  parameter int INST_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  alu_sched_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + INST_W + 2 * DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [0:0] S_WAIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              last_q, last_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ENT_W-1:0]  mem_d [DEPTH];
  logic [INST_W-1:0] alu_inst_q, alu_inst_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              cur_id_q, cur_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              grant0, grant1, not_full, push, issue;
  logic [ENT_W-1:0]  push_ent, head_ent;
  logic              head_id;
  logic [INST_W-1:0] head_inst;
  logic [DATA_W-1:0] head_a, head_b;

  // Round-robin arbitration and push selection; `last` follows each push.
  always_comb begin
    grant0   = bus.i_req0_valid && (!bus.i_req1_valid || last_q);
    grant1   = bus.i_req1_valid && !grant0;
    not_full = cnt_q < FULL_CNT;
    push     = (grant0 || grant1) && not_full;
    push_ent = grant0 ? {1'b0, bus.i_req0_inst, bus.i_req0_a, bus.i_req0_b}
                      : {1'b1, bus.i_req1_inst, bus.i_req1_a, bus.i_req1_b};
    last_d   = push ? grant1 : last_q;
  end

  // FIFO head decode.
  always_comb begin
    head_ent  = mem_q[rd_ptr_q];
    head_id   = head_ent[ENT_W-1];
    head_inst = head_ent[ENT_W-2 -: INST_W];
    head_a    = head_ent[2*DATA_W-1 -: DATA_W];
    head_b    = head_ent[DATA_W-1:0];
  end

  // FIFO storage, pointers and occupancy; push and pop may coincide.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_ent;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(issue);
  end

  // Issue FSM and response register.
  always_comb begin
    state_d     = state_q;
    alu_inst_d  = alu_inst_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    cur_id_d    = cur_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    issue       = 1'b0;
    if (rsp_valid_q && bus.i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    case (state_q)
      S_WAIT: begin
        // Valid pulses seen here belong to filler slots and are dropped.
        issue = !bus.i_alu_busy && (cnt_q != '0) && !rsp_valid_q;
        if (issue) begin
          alu_inst_d = head_inst;
          alu_a_d    = head_a;
          alu_b_d    = head_b;
          cur_id_d   = head_id;
          state_d    = S_RUN;
        end else begin
          alu_inst_d = '0;
          alu_a_d    = '0;
          alu_b_d    = '0;
        end
      end
      S_RUN: begin
        if (bus.i_alu_valid) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id_q;
          rsp_data_d  = bus.i_alu_data;
          state_d     = S_WAIT;
        end
      end
    endcase
  end

  // Control and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_WAIT;
      last_q      <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      alu_inst_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      cur_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      alu_inst_q  <= alu_inst_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      cur_id_q    <= cur_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // FIFO payload storage needs no reset; occupancy guards every read.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign bus.o_req0_ready = grant0 && not_full;
  assign bus.o_req1_ready = grant1 && not_full;
  assign bus.o_alu_inst   = alu_inst_q;
  assign bus.o_alu_a      = alu_a_q;
  assign bus.o_alu_b      = alu_b_q;
  assign bus.o_rsp_valid  = rsp_valid_q;
  assign bus.o_rsp_id     = rsp_id_q;
  assign bus.o_rsp_data   = rsp_data_q;
  assign bus.o_fifo_cnt   = cnt_q;
endmodule

// File: doc/alu_sched.md
# alu_sched

Command scheduler that shares the fixed-point ALU between two requesters. Each requester presents a command of the form {inst, a, b}. A round-robin arbiter pushes the winning command into a small FIFO. A sequencing FSM issues the FIFO head to the ALU in step with the ALU's busy/valid handshake and returns each result, tagged with the requester ID, through a single-entry response register. It sits directly in front of `alu`: its outputs drive the ALU operand/instruction inputs, and it consumes the ALU's `o_busy`, `o_valid` and `o_data`.

## Interface
- DATA_W, 16, operand/result width (matches ALU)
- INST_W, 4, instruction width (matches ALU)
- DEPTH, 4, command FIFO entries (power of 2, ≥2)
- i_clk  in  1  clock; all state on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_req0_valid / i_req1_valid  in  1  requester command valid
- o_req0_ready / o_req1_ready  out  1  command accepted this cycle when valid&&ready
- i_req0_inst / i_req1_inst  in  INST_W  ALU opcode
- i_req0_a / i_req1_a, i_req0_b / i_req1_b  in  DATA_W  operands
- o_alu_inst  out  INST_W  to ALU i_inst
- o_alu_a / o_alu_b  out  DATA_W  to ALU i_data_a / i_data_b
- i_alu_busy  in  1  ALU o_busy
- i_alu_valid  in  1  ALU o_valid
- i_alu_data  in  DATA_W  ALU o_data
- o_rsp_valid  out  1  response held valid until taken
- i_rsp_ready  in  1  response consumer ready
- o_rsp_id  out  1  requester that issued the command
- o_rsp_data  out  DATA_W  ALU result
- o_fifo_cnt  out  $clog2(DEPTH)+1  occupied FIFO entries

## Operation
**Arbiter**
- `last` register, reset 1.
- grant0 = i_req0_valid && (!i_req1_valid || last==1).
- grant1 = i_req1_valid && !grant0.
- o_reqK_ready = grantK && (o_fifo_cnt < DEPTH). This is combinational from the valids. There is no push-through when the FIFO is full.
- On a push, `last` takes the ID of the granted requester. At most one push per cycle.

**FIFO**
- Entry layout is {id, inst, a, b}.
- Push and pop in the same cycle are legal: count is unchanged and the pointers wrap modulo DEPTH.

**FSM**
- S_WAIT (reset state):
  - Issue condition: !i_alu_busy && o_fifo_cnt!=0 && !o_rsp_valid.
  - When the condition holds: pop the head, register inst/a/b into o_alu_*, latch id into `cur_id`, go to S_RUN.
  - When it does not hold: register the filler command into o_alu_*: inst=4'h0 (fx_add), a=0, b=0.
- S_RUN:
  - o_alu_* are held constant.
  - On i_alu_valid: o_rsp_data<=i_alu_data, o_rsp_id<=cur_id, o_rsp_valid<=1, then go to S_WAIT.
- Response register:
  - o_rsp_valid is cleared on i_rsp_ready && o_rsp_valid.
  - It cannot be set again in the same cycle, because no issue is allowed while it is valid.
- i_alu_valid in S_WAIT comes from a filler slot. It is ignored and produces no response.
- Filler slots return 0, so the ALU MAC accumulator is cleared by every idle slot. MAC chains only accumulate when their commands issue in consecutive busy-low windows.

**Reset values**
- o_alu_inst=0, o_alu_a=0, o_alu_b=0.
- o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0.
- o_fifo_cnt=0, FIFO pointers 0, `last`=1, state S_WAIT.
- Reset mid-S_RUN: the pending command is dropped and no response is produced for it. A subsequent i_alu_valid from that operation arrives in S_WAIT and is ignored.

## Timing
- The ALU drops busy for exactly one cycle (its getdata cycle, T). It samples operands the next cycle (T+1).
- The issue is registered at the end of T, so o_alu_* are stable from T+1 until the response is captured.
- Single-cycle ops: i_alu_valid arrives at T+2 and o_rsp_valid rises at T+3.
- lrcw/lfsr: i_alu_valid arrives after 1–16 extra cycles. The FSM waits indefinitely in S_RUN; there is no timeout.
- Request to response, empty system with a single-cycle op: the FIFO entry is visible 1 cycle after the push. The remaining latency is the wait for the next busy-low window (≤4 cycles) plus 3 cycles.
- Throughput is one command per ALU round (4 cycles for single-cycle ops), provided i_rsp_ready is held high.
- o_fifo_cnt updates one cycle after a push or pop.

## Test plan
- **Single command:** req0 fx_add with a=0x0400, b=0x0800 → one response, o_rsp_id=0, o_rsp_data=0x0C00. No other o_rsp_valid pulses within 40 cycles.
- **Round-robin arbitration:** both requesters valid continuously for 3 pushes each. Use req0 fx_add a=0x0400,b=0 and req1 fx_add a=0x0800,b=0 → push order 0,1,0,1,0,1 (req0 first after reset). Response ids alternate in the same order with data 0x0400 / 0x0800.
- **FIFO full and response back-pressure** (DEPTH=4, i_rsp_ready=0): 5 commands from req0 → first 4 accepted, o_req0_ready=0 at cnt=4. One issue occurs, then cnt=3 and the 5th command is accepted. Afterwards o_fifo_cnt stays 4 with no further issue until i_rsp_ready=1, after which the responses drain in order.
- **Long op:** lfsr with a=0x0001, b=0x000F → o_alu_a/b/inst are constant throughout S_RUN. Exactly one response, equal to the 15-step LFSR value.
- **Idle filler:** no requests for 40 cycles → o_alu_inst=0 and o_alu_a=o_alu_b=0 throughout. Zero o_rsp_valid pulses despite repeated i_alu_valid.
- **Reset mid-operation:** assert i_rst_n=0 for one cycle during the S_RUN of an lfsr (b=0x000F) command → all outputs return to reset values. The late i_alu_valid produces no response, and the next command completes normally.
